// File: rtl/instr_encoder.sv
// MIPS instruction encoder feeding a 4-entry output FIFO with address tagging.
// Define ENC_FIELD_CHECK_EN to flag nonzero fields that the encoding forces to zero.
module instr_encoder (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  op_sel,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic [31:0] out_addr,
  output logic [2:0]  count,
  output logic        err_illegal,
  output logic        err_field
);

  localparam logic [31:0] BASE_ADDR = 32'h0000_3000;

  logic [31:0] word_q [4];
  logic [31:0] word_d [4];
  logic [31:0] addr_q [4];
  logic [31:0] addr_d [4];
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [2:0]  count_q, count_d;
  logic [31:0] addr_cnt_q, addr_cnt_d;
  logic        err_illegal_q, err_illegal_d;
  logic        ready_en_q;

  logic [31:0] enc_word;
  logic        enc_legal;
  logic        field_bad;
  logic        accept;
  logic        push;
  logic        pop;

  // Unused fields are simply left out of the concatenation, which masks them.
  always_comb begin
    enc_word  = 32'h0;
    enc_legal = 1'b1;
    case (op_sel)
      4'd0:    enc_word = {6'h00, rs, rt, rd, 5'd0, 6'h21};
      4'd1:    enc_word = {6'h00, rs, rt, rd, 5'd0, 6'h23};
      4'd2:    enc_word = {6'h0D, rs, rt, imm};
      4'd3:    enc_word = {6'h23, rs, rt, imm};
      4'd4:    enc_word = {6'h2B, rs, rt, imm};
      4'd5:    enc_word = {6'h04, rs, rt, imm};
      4'd6:    enc_word = {6'h0F, 5'd0, rt, imm};
      4'd7:    enc_word = {6'h02, target};
      4'd8:    enc_word = {6'h03, target};
      4'd9:    enc_word = {6'h00, rs, 15'd0, 6'h08};
      4'd10:   enc_word = {6'h00, 5'd0, rt, rd, shamt, 6'h00};
      default: enc_legal = 1'b0;
    endcase
  end

`ifdef ENC_FIELD_CHECK_EN
  logic err_field_q, err_field_d;

  always_comb begin
    field_bad = 1'b0;
    case (op_sel)
      4'd0, 4'd1: field_bad = (shamt != 5'd0);
      4'd6:       field_bad = (rs != 5'd0);
      4'd9:       field_bad = (rt != 5'd0) || (rd != 5'd0) || (shamt != 5'd0);
      4'd10:      field_bad = (rs != 5'd0);
      default:    field_bad = 1'b0;
    endcase
  end

  always_comb begin
    err_field_d = err_field_q;
    if (flush)
      err_field_d = 1'b0;
    else if (push && field_bad)
      err_field_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      err_field_q <= 1'b0;
    else
      err_field_q <= err_field_d;
  end

  assign err_field = err_field_q;
`else
  assign field_bad = 1'b0;
  assign err_field = 1'b0;
`endif

  // ready_en_q keeps the port closed on the first edge after reset release.
  assign in_ready  = ready_en_q && (count_q != 3'd4);
  assign accept    = in_valid && in_ready;
  assign push      = accept && enc_legal && !flush;
  assign pop       = out_valid && out_ready && !flush;

  assign out_valid   = (count_q != 3'd0);
  assign out_word    = word_q[rd_ptr_q];
  assign out_addr    = addr_q[rd_ptr_q];
  assign count       = count_q;
  assign err_illegal = err_illegal_q;

  always_comb begin
    word_d        = word_q;
    addr_d        = addr_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    addr_cnt_d    = addr_cnt_q;
    err_illegal_d = err_illegal_q;
    if (flush) begin
      rd_ptr_d      = 2'd0;
      wr_ptr_d      = 2'd0;
      count_d       = 3'd0;
      addr_cnt_d    = BASE_ADDR;
      err_illegal_d = 1'b0;
    end else begin
      if (push) begin
        word_d[wr_ptr_q] = enc_word;
        addr_d[wr_ptr_q] = addr_cnt_q;
        wr_ptr_d         = wr_ptr_q + 2'd1;
        addr_cnt_d       = addr_cnt_q + 32'd4;
      end
      if (pop)
        rd_ptr_d = rd_ptr_q + 2'd1;
      count_d = count_q + {2'b00, push} - {2'b00, pop};
      if (accept && !enc_legal)
        err_illegal_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        word_q[i] <= 32'h0;
        addr_q[i] <= BASE_ADDR;
      end
      rd_ptr_q      <= 2'd0;
      wr_ptr_q      <= 2'd0;
      count_q       <= 3'd0;
      addr_cnt_q    <= BASE_ADDR;
      err_illegal_q <= 1'b0;
      ready_en_q    <= 1'b0;
    end else begin
      word_q        <= word_d;
      addr_q        <= addr_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      addr_cnt_q    <= addr_cnt_d;
      err_illegal_q <= err_illegal_d;
      ready_en_q    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed testbench for instr_encoder: table of single-command encodings
// plus hand-written sequences for backpressure, illegal ops, flush and reset.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op_sel;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [25:0] target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [31:0] out_addr;
  logic [2:0]  count;
  logic        err_illegal;
  logic        err_field;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_addr;
  logic        exp_fe;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [25:0] target;
    logic [31:0] word;
  } vec_t;

  vec_t vecs [11];

  always #5 clk = ~clk;

  instr_encoder dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op_sel      (op_sel),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .shamt       (shamt),
    .imm         (imm),
    .target      (target),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_word    (out_word),
    .out_addr    (out_addr),
    .count       (count),
    .err_illegal (err_illegal),
    .err_field   (err_field)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [3:0] op_i, input logic [4:0] rs_i,
                                input logic [4:0] rt_i, input logic [4:0] rd_i,
                                input logic [4:0] sh_i, input logic [15:0] imm_i,
                                input logic [25:0] tgt_i);
    op_sel   = op_i;
    rs       = rs_i;
    rt       = rt_i;
    rd       = rd_i;
    shamt    = sh_i;
    imm      = imm_i;
    target   = tgt_i;
    in_valid = 1'b1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    op_sel   = 4'd0;
    rs       = 5'd0;
    rt       = 5'd0;
    rd       = 5'd0;
    shamt    = 5'd0;
    imm      = 16'd0;
    target   = 26'd0;
  endtask

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
`ifdef ENC_FIELD_CHECK_EN
    exp_fe = 1'b1;
`else
    exp_fe = 1'b0;
`endif
    vecs[0]  = '{"addu",  4'd0,  5'd1,  5'd2,  5'd3, 5'd0, 16'h0000, 26'h0,       32'h0022_1821};
    vecs[1]  = '{"subu",  4'd1,  5'd4,  5'd5,  5'd6, 5'd0, 16'h0000, 26'h0,       32'h0085_3023};
    vecs[2]  = '{"ori",   4'd2,  5'd0,  5'd8,  5'd0, 5'd0, 16'h1234, 26'h0,       32'h3408_1234};
    vecs[3]  = '{"lw",    4'd3,  5'd29, 5'd2,  5'd0, 5'd0, 16'h0010, 26'h0,       32'h8FA2_0010};
    vecs[4]  = '{"sw",    4'd4,  5'd29, 5'd31, 5'd0, 5'd0, 16'hFFFC, 26'h0,       32'hAFBF_FFFC};
    vecs[5]  = '{"beq",   4'd5,  5'd1,  5'd0,  5'd0, 5'd0, 16'hFFFF, 26'h0,       32'h1020_FFFF};
    vecs[6]  = '{"lui",   4'd6,  5'd0,  5'd9,  5'd0, 5'd0, 16'hABCD, 26'h0,       32'h3C09_ABCD};
    vecs[7]  = '{"j",     4'd7,  5'd0,  5'd0,  5'd0, 5'd0, 16'h0000, 26'h0000C00, 32'h0800_0C00};
    vecs[8]  = '{"jal",   4'd8,  5'd0,  5'd0,  5'd0, 5'd0, 16'h0000, 26'h3FFFFFF, 32'h0FFF_FFFF};
    vecs[9]  = '{"sll",   4'd10, 5'd0,  5'd3,  5'd4, 5'd2, 16'h0000, 26'h0,       32'h0003_2080};
    vecs[10] = '{"jr",    4'd9,  5'd31, 5'd0,  5'd0, 5'd0, 16'h0000, 26'h0,       32'h03E0_0008};

    reset_n   = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    idle();

    #12;
    check_output("rst_count",       {29'd0, count}, 32'd0);
    check_output("rst_out_valid",   {31'd0, out_valid}, 32'd0);
    check_output("rst_out_word",    out_word, 32'h0);
    check_output("rst_out_addr",    out_addr, 32'h0000_3000);
    check_output("rst_err_illegal", {31'd0, err_illegal}, 32'd0);
    check_output("rst_err_field",   {31'd0, err_field}, 32'd0);
    check_output("rst_in_ready",    {31'd0, in_ready}, 32'd0);

    // Command held across reset release must not be taken on the first edge.
    apply_stimulus(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    tick();
    reset_n = 1'b1;
    tick();
    check_output("first_edge_no_accept", {29'd0, count}, 32'd0);
    check_output("in_ready_after_rst",   {31'd0, in_ready}, 32'd1);
    tick();
    idle();
    check_output("addu_count",     {29'd0, count}, 32'd1);
    check_output("addu_out_valid", {31'd0, out_valid}, 32'd1);
    check_output("addu_word",      out_word, 32'h0022_1821);
    check_output("addu_addr",      out_addr, 32'h0000_3000);
    exp_addr = 32'h0000_3004;
    pop_one();
    check_output("addu_popped", {29'd0, count}, 32'd0);

    for (int i = 0; i < 11; i++) begin
      apply_stimulus(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd,
                     vecs[i].shamt, vecs[i].imm, vecs[i].target);
      tick();
      idle();
      check_output({"tbl_word_", vecs[i].name},  out_word, vecs[i].word);
      check_output({"tbl_addr_", vecs[i].name},  out_addr, exp_addr);
      check_output({"tbl_count_", vecs[i].name}, {29'd0, count}, 32'd1);
      exp_addr = exp_addr + 32'd4;
      pop_one();
      check_output({"tbl_empty_", vecs[i].name}, {29'd0, count}, 32'd0);
    end
    check_output("tbl_err_illegal", {31'd0, err_illegal}, 32'd0);
    check_output("tbl_err_field",   {31'd0, err_field}, 32'd0);

    // Two words queued under backpressure, then drained in order.
    apply_stimulus(4'd2, 5'd0, 5'd8, 5'd0, 5'd0, 16'h1234, 26'h0);
    tick();
    apply_stimulus(4'd6, 5'd0, 5'd9, 5'd0, 5'd0, 16'hABCD, 26'h0);
    tick();
    idle();
    check_output("bp_count2",     {29'd0, count}, 32'd2);
    check_output("bp_head_word",  out_word, 32'h3408_1234);
    check_output("bp_head_addr",  out_addr, exp_addr);
    out_ready = 1'b1;
    tick();
    check_output("bp_second_word", out_word, 32'h3C09_ABCD);
    check_output("bp_second_addr", out_addr, exp_addr + 32'd4);
    check_output("bp_count1",      {29'd0, count}, 32'd1);
    tick();
    out_ready = 1'b0;
    check_output("bp_count0", {29'd0, count}, 32'd0);

    // Fill to four, confirm a pop on a full FIFO refuses the simultaneous push.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_output("flush_empty", {29'd0, count}, 32'd0);
    apply_stimulus(4'd7, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000C00);
    for (int i = 0; i < 4; i++) tick();
    check_output("full_count",    {29'd0, count}, 32'd4);
    check_output("full_in_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_output("full_pop_no_push", {29'd0, count}, 32'd3);
    check_output("full_slot_freed",  {31'd0, in_ready}, 32'd1);
    check_output("full_head_addr",   out_addr, 32'h0000_3004);
    tick();
    idle();
    check_output("full_refill", {29'd0, count}, 32'd4);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check_output("drain_word", out_word, 32'h0800_0C00);
      check_output("drain_addr", out_addr, 32'h0000_3000 + 32'(4 * i));
      tick();
    end
    out_ready = 1'b0;
    check_output("drain_empty", {29'd0, count}, 32'd0);
    exp_addr = 32'h0000_3014;

    // Illegal op is dropped without consuming an address.
    apply_stimulus(4'd12, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1);
    tick();
    idle();
    check_output("illegal_flag",  {31'd0, err_illegal}, 32'd1);
    check_output("illegal_count", {29'd0, count}, 32'd0);
    check_output("illegal_valid", {31'd0, out_valid}, 32'd0);
    apply_stimulus(4'd8, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h1);
    tick();
    idle();
    check_output("jal_word", out_word, 32'h0C00_0001);
    check_output("jal_addr", out_addr, exp_addr);
    exp_addr = exp_addr + 32'd4;
    pop_one();
    check_output("illegal_sticky", {31'd0, err_illegal}, 32'd1);

    // Nonzero forced-zero fields: masked in the word, flagged only when checked.
    check_output("field_pre", {31'd0, err_field}, 32'd0);
    apply_stimulus(4'd9, 5'd31, 5'd5, 5'd0, 5'd0, 16'h0, 26'h0);
    tick();
    idle();
    check_output("jr_masked_word", out_word, 32'h03E0_0008);
    check_output("jr_err_field",   {31'd0, err_field}, {31'd0, exp_fe});
    pop_one();
    apply_stimulus(4'd10, 5'd7, 5'd3, 5'd4, 5'd2, 16'h0, 26'h0);
    tick();
    idle();
    check_output("sll_masked_word", out_word, 32'h0003_2080);
    check_output("sll_masked_addr", out_addr, exp_addr + 32'd4);
    pop_one();

    // Flush wins over a simultaneous push with three words queued.
    apply_stimulus(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    for (int i = 0; i < 3; i++) tick();
    check_output("pre_flush_count", {29'd0, count}, 32'd3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    check_output("flush_count",       {29'd0, count}, 32'd0);
    check_output("flush_out_valid",   {31'd0, out_valid}, 32'd0);
    check_output("flush_err_illegal", {31'd0, err_illegal}, 32'd0);
    check_output("flush_err_field",   {31'd0, err_field}, 32'd0);
    apply_stimulus(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    tick();
    check_output("post_flush_addr", out_addr, 32'h0000_3000);
    check_output("post_flush_word", out_word, 32'h0022_1821);
    apply_stimulus(4'd11, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    tick();
    idle();
    check_output("pre_rst_count",   {29'd0, count}, 32'd1);
    check_output("pre_rst_illegal", {31'd0, err_illegal}, 32'd1);

    // Asynchronous reset mid-stream, sampled between clock edges.
    #2;
    reset_n = 1'b0;
    #1;
    check_output("mid_rst_count",       {29'd0, count}, 32'd0);
    check_output("mid_rst_out_valid",   {31'd0, out_valid}, 32'd0);
    check_output("mid_rst_out_word",    out_word, 32'h0);
    check_output("mid_rst_out_addr",    out_addr, 32'h0000_3000);
    check_output("mid_rst_err_illegal", {31'd0, err_illegal}, 32'd0);
    check_output("mid_rst_err_field",   {31'd0, err_field}, 32'd0);
    check_output("mid_rst_in_ready",    {31'd0, in_ready}, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    apply_stimulus(4'd7, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000C00);
    tick();
    idle();
    check_output("post_rst_word", out_word, 32'h0800_0C00);
    check_output("post_rst_addr", out_addr, 32'h0000_3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
